// File: rtl/usb_token_rx_ctrl_pkg.sv
// Shared types and constants for the USB token receive controller.
// Covers the controller FSM state encoding and the token field geometry.
package usb_token_rx_ctrl_pkg;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_ENDP_W = 4;
  localparam int DEF_CRC_W  = 5;
  localparam int TOKEN_BITS = DEF_ADDR_W + DEF_ENDP_W + DEF_CRC_W;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_SETTLE   = 2'd2,
    ST_WAIT_EOP = 2'd3
  } rx_state_e;

endpackage

// File: rtl/usb_token_rx_ctrl_if.sv
// Token receive bundle: bit-stream inputs, CRC5 unit handshake and token results.
// master drives the stream and CRC flag, slave is the token controller.
interface usb_token_rx_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int ENDP_W = 4
);
  logic              token_start;
  logic              bit_valid;
  logic              d_bit;
  logic              eop;
  logic              crc_ok;
  logic              crc_clear;
  logic              shift_enable;
  logic [ADDR_W-1:0] addr;
  logic [ENDP_W-1:0] endp;
  logic              token_valid;
  logic              token_error;
  logic              busy;

  modport master (
    output token_start, bit_valid, d_bit, eop, crc_ok,
    input  crc_clear, shift_enable, addr, endp, token_valid, token_error, busy
  );

  modport slave (
    input  token_start, bit_valid, d_bit, eop, crc_ok,
    output crc_clear, shift_enable, addr, endp, token_valid, token_error, busy
  );
endinterface

// File: rtl/usb_token_rx_ctrl_bit_counter.sv
// Token bit counter with synchronous clear, count enable and terminal-count flag.
module usb_token_rx_ctrl_bit_counter #(
  parameter int W    = 5,
  parameter int LAST = 15
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         terminal
);

  // Counts accepted token bits; clear has priority over enable.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

  assign terminal = (count == W'(LAST));

endmodule

// File: rtl/usb_token_rx_ctrl.sv
// Receive-side token sequencer: feeds ADDR/ENDP/CRC5 bits to the external CRC5 unit,
// captures ADDR/ENDP and reports a valid or erroneous token at end of packet.
module usb_token_rx_ctrl
  import usb_token_rx_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ENDP_W = DEF_ENDP_W,
  parameter int CRC_W  = DEF_CRC_W
) (
  input logic                clk,
  input logic                n_rst,
  usb_token_rx_ctrl_if.slave rx
);

  localparam int FIELD_W    = ADDR_W + ENDP_W;
  localparam int TOTAL_BITS = FIELD_W + CRC_W;

  rx_state_e          state_r;
  logic               ok_r;
  logic               valid_r;
  logic               error_r;
  logic               busy_r;
  logic [FIELD_W-1:0] field_r;
  logic [FIELD_W-1:0] field_next_s;
  logic [ADDR_W-1:0]  addr_r;
  logic [ENDP_W-1:0]  endp_r;
  logic [CNT_W-1:0]   count_s;
  logic               terminal_s;
  logic               shift_en_s;
  logic               advance_s;
  logic               capture_s;
  logic               last_field_s;
  logic               last_bit_s;
  logic               ok_sel_s;

  assign rx.crc_clear    = rx.token_start;
  assign shift_en_s      = rx.bit_valid & (state_r == ST_SHIFT) & ~rx.token_start;
  assign rx.shift_enable = shift_en_s;

  // A bit that coincides with eop is not part of the token and is never counted.
  assign advance_s    = shift_en_s & ~rx.eop;
  assign capture_s    = advance_s & (count_s < CNT_W'(FIELD_W));
  assign last_field_s = advance_s & (count_s == CNT_W'(FIELD_W - 1));
  assign last_bit_s   = advance_s & terminal_s;
  assign field_next_s = {rx.d_bit, field_r[FIELD_W-1:1]};

  // In SETTLE the CRC flag is taken live; afterwards the latched copy is used.
  assign ok_sel_s = (state_r == ST_SETTLE) ? rx.crc_ok : ok_r;

  usb_token_rx_ctrl_bit_counter #(
    .W    (CNT_W),
    .LAST (TOTAL_BITS - 1)
  ) u_bit_counter (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (rx.token_start),
    .enable   (advance_s),
    .count    (count_s),
    .terminal (terminal_s)
  );

  // LSB-first field shift register; ADDR/ENDP are published on the last field bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      field_r <= '0;
      addr_r  <= '0;
      endp_r  <= '0;
    end else if (capture_s) begin
      field_r <= field_next_s;
      if (last_field_s) begin
        addr_r <= field_next_s[ADDR_W-1:0];
        endp_r <= field_next_s[FIELD_W-1:ADDR_W];
      end else begin
        addr_r <= addr_r;
        endp_r <= endp_r;
      end
    end else begin
      field_r <= field_r;
      addr_r  <= addr_r;
      endp_r  <= endp_r;
    end
  end

  // Packet sequencer with registered result pulses and busy flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= ST_IDLE;
      ok_r    <= 1'b0;
      valid_r <= 1'b0;
      error_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      error_r <= 1'b0;
      if (rx.token_start) begin
        // A new PID abandons whatever packet was in flight without a result.
        state_r <= ST_SHIFT;
        ok_r    <= 1'b0;
        busy_r  <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_SHIFT: begin
            if (rx.eop) begin
              error_r <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else if (last_bit_s) begin
              state_r <= ST_SETTLE;
            end else begin
              state_r <= ST_SHIFT;
            end
          end
          ST_SETTLE, ST_WAIT_EOP: begin
            ok_r <= ok_sel_s;
            if (rx.eop) begin
              valid_r <= ok_sel_s;
              error_r <= ~ok_sel_s;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else if (rx.bit_valid) begin
              error_r <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_WAIT_EOP;
            end
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign rx.addr        = addr_r;
  assign rx.endp        = endp_r;
  assign rx.token_valid = valid_r;
  assign rx.token_error = error_r;
  assign rx.busy        = busy_r;

endmodule

// File: tb/tb_usb_token_rx_ctrl.sv
// Randomized self-checking bench for usb_token_rx_ctrl with a bit-serial CRC5 unit
// model and a packet-level reference model of the expected token outcome.
module tb_usb_token_rx_ctrl;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  usb_token_rx_ctrl_if bus ();

  usb_token_rx_ctrl dut (
    .clk   (clk),
    .n_rst (n_rst),
    .rx    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int se_cnt   = 0;
  int clr_cnt  = 0;
  int v_cnt    = 0;
  int e_cnt    = 0;
  logic [6:0] model_addr = 7'd0;
  logic [3:0] model_endp = 4'd0;
  logic [4:0] crc_reg;

  function automatic logic [4:0] crc_step(input logic [4:0] c, input logic d);
    logic fb;
    fb = d ^ c[4];
    return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
  endfunction

  // Transmitted CRC field for an 11-bit token field; bit i goes on the wire i-th.
  function automatic logic [4:0] ref_crc_bits(input logic [10:0] f);
    logic [4:0] c;
    logic [4:0] t;
    c = 5'b11111;
    for (int i = 0; i < 11; i++) c = crc_step(c, f[i]);
    for (int i = 0; i < 5; i++) t[i] = ~c[4-i];
    return t;
  endfunction

  // External CRC5 unit: preset on crc_clear, advance on shift_enable.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) crc_reg <= 5'b11111;
    else if (bus.crc_clear) crc_reg <= 5'b11111;
    else if (bus.shift_enable) crc_reg <= crc_step(crc_reg, bus.d_bit);
  end
  assign bus.crc_ok = (crc_reg == 5'b01100);

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.shift_enable) se_cnt <= se_cnt + 1;
    if (bus.crc_clear) clr_cnt <= clr_cnt + 1;
    if (bus.token_valid) v_cnt <= v_cnt + 1;
    if (bus.token_error) e_cnt <= e_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_packet(input logic [10:0] field, input bit bad_crc, input int nbits,
                            input int gap, input int tail, input bit eop_with_bit,
                            input bit start_with_bit, input string tag);
    logic [16:0] bits;
    logic [4:0]  cb;
    int base_se, base_clr, base_v, base_e, n_send, n_shifted, exp_se;
    bit exp_valid;
    cb = ref_crc_bits(field);
    if (bad_crc) cb = cb ^ (5'b00001 << $urandom_range(4, 0));
    bits = {1'($urandom_range(1, 0)), cb, field};
    base_se = se_cnt; base_clr = clr_cnt; base_v = v_cnt; base_e = e_cnt;
    bus.token_start = 1'b1;
    bus.bit_valid   = start_with_bit;
    bus.d_bit       = 1'($urandom_range(1, 0));
    tick();
    bus.token_start = 1'b0;
    bus.bit_valid   = 1'b0;
    check_eq({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    n_send = (nbits > 16) ? 17 : nbits;
    for (int i = 0; i < n_send; i++) begin
      if (i > 0) repeat (gap - 1) tick();
      if (i == 16) repeat (tail) tick();
      bus.bit_valid = 1'b1;
      bus.d_bit     = bits[i];
      tick();
      bus.bit_valid = 1'b0;
    end
    if (nbits <= 16) begin
      repeat (tail) tick();
      bus.eop = 1'b1;
      if (eop_with_bit && nbits < 16) begin
        bus.bit_valid = 1'b1;
        bus.d_bit     = 1'($urandom_range(1, 0));
      end
      tick();
      bus.eop       = 1'b0;
      bus.bit_valid = 1'b0;
    end
    n_shifted = (nbits > 16) ? 16 : nbits;
    exp_se    = n_shifted + ((eop_with_bit && nbits < 16) ? 1 : 0);
    exp_valid = (nbits == 16) && !bad_crc;
    if (n_shifted >= 11) begin
      model_addr = field[6:0];
      model_endp = field[10:7];
    end
    check_eq({tag, "_valid"}, 32'(bus.token_valid), 32'(exp_valid));
    check_eq({tag, "_error"}, 32'(bus.token_error), 32'(!exp_valid));
    check_eq({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_addr"}, 32'(bus.addr), 32'(model_addr));
    check_eq({tag, "_endp"}, 32'(bus.endp), 32'(model_endp));
    check_eq({tag, "_shifts"}, 32'(se_cnt - base_se), 32'(exp_se));
    check_eq({tag, "_clears"}, 32'(clr_cnt - base_clr), 32'd1);
    tick();
    check_eq({tag, "_pulse_end"}, 32'({bus.token_valid, bus.token_error}), 32'd0);
    if (nbits > 16) begin
      bus.eop = 1'b1;
      tick();
      bus.eop = 1'b0;
      tick();
    end
    check_eq({tag, "_nvalid"}, 32'(v_cnt - base_v), 32'(exp_valid));
    check_eq({tag, "_nerror"}, 32'(e_cnt - base_e), 32'(!exp_valid));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_v, base_e, base_clr;
    int kind, nb;
    logic [10:0] f;
    bus.token_start = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.d_bit       = 1'b0;
    bus.eop         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_addr", 32'(bus.addr), 32'd0);
    check_eq("rst_endp", 32'(bus.endp), 32'd0);
    check_eq("rst_pulses", 32'({bus.token_valid, bus.token_error}), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    run_packet(11'h000, 1'b0, 16, 1, 1, 1'b0, 1'b0, "t1_zero");
    run_packet({4'hE, 7'h15}, 1'b0, 16, 4, 1, 1'b0, 1'b0, "t2_good");
    run_packet({4'hE, 7'h15}, 1'b1, 16, 4, 1, 1'b0, 1'b0, "t3_badcrc");
    run_packet(11'h5A3, 1'b0, 9, 1, 1, 1'b0, 1'b0, "t4_short");
    run_packet(11'h2C7, 1'b0, 17, 1, 1, 1'b0, 1'b0, "t4_long");
    run_packet(11'h3F1, 1'b0, 13, 2, 0, 1'b1, 1'b0, "eop_bit");
    run_packet(11'h4B6, 1'b0, 16, 1, 0, 1'b0, 1'b0, "eop_settle");

    // Abort after six bits; the restart also carries a bit that must not shift.
    base_v = v_cnt; base_e = e_cnt; base_clr = clr_cnt;
    bus.token_start = 1'b1;
    tick();
    bus.token_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.bit_valid = 1'b1;
      bus.d_bit     = 1'($urandom_range(1, 0));
      tick();
      bus.bit_valid = 1'b0;
    end
    run_packet(11'h61D, 1'b0, 16, 1, 1, 1'b0, 1'b1, "t5_restart");
    check_eq("t5_total_clears", 32'(clr_cnt - base_clr), 32'd2);
    check_eq("t5_total_valid", 32'(v_cnt - base_v), 32'd1);
    check_eq("t5_total_error", 32'(e_cnt - base_e), 32'd0);

    // Reset in the middle of the CRC bits.
    f = 11'h7AB;
    bus.token_start = 1'b1;
    tick();
    bus.token_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.bit_valid = 1'b1;
      bus.d_bit     = f[i % 11];
      tick();
      bus.bit_valid = 1'b0;
    end
    check_eq("t6_addr_before", 32'(bus.addr), 32'(f[6:0]));
    #3;
    n_rst = 1'b0;
    #1;
    check_eq("t6_addr", 32'(bus.addr), 32'd0);
    check_eq("t6_endp", 32'(bus.endp), 32'd0);
    check_eq("t6_busy", 32'(bus.busy), 32'd0);
    check_eq("t6_pulses", 32'({bus.token_valid, bus.token_error}), 32'd0);
    model_addr = 7'd0;
    model_endp = 4'd0;
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    run_packet(11'h155, 1'b0, 16, 2, 1, 1'b0, 1'b0, "t6_after");

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(3, 0);
      f    = 11'($urandom_range(2047, 0));
      case (kind)
        0: run_packet(f, 1'b0, 16, $urandom_range(3, 1), $urandom_range(3, 0), 1'b0, 1'b0, "rnd_good");
        1: run_packet(f, 1'b1, 16, $urandom_range(3, 1), $urandom_range(3, 0), 1'b0, 1'b0, "rnd_bad");
        2: begin
          nb = $urandom_range(15, 1);
          run_packet(f, 1'b0, nb, $urandom_range(3, 1), $urandom_range(3, 0),
                     1'($urandom_range(1, 0)), 1'b0, "rnd_short");
        end
        default: run_packet(f, 1'b0, 17, $urandom_range(3, 1), $urandom_range(3, 0), 1'b0, 1'b0, "rnd_long");
      endcase
      // Stray strobes while idle must be ignored.
      base_v = v_cnt; base_e = e_cnt;
      bus.eop       = 1'($urandom_range(1, 0));
      bus.bit_valid = 1'($urandom_range(1, 0));
      tick();
      bus.eop       = 1'b0;
      bus.bit_valid = 1'b0;
      tick();
      check_eq("idle_ignore", 32'((v_cnt - base_v) + (e_cnt - base_e)), 32'd0);
      check_eq("idle_busy", 32'(bus.busy), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
